// File: rtl/dcache_replace_logic_if.sv
// ---------------------------------------------------------------------------
// dcache_replace_logic_if
// Bundles every non-clock/reset signal of the D$ replace engine. There are
// three groups:
//   - the command channel from the D$ access pipeline
//   - the D$ valid/dirty/tag/data array port
//   - the line-granular memory bus
// Modports:
//   slave  : the replace engine (takes commands, drives the array write port
//            and the memory requests)
//   master : the environment (pipeline, arrays, memory)
// ---------------------------------------------------------------------------
interface dcache_replace_logic_if #(
    parameter int LINE_WIDTH  = 128,
    parameter int INDEX_WIDTH = 4,
    parameter int TAG_WIDTH   = 26
);
    // command channel
    logic                           cmd_valid;
    logic [1:0]                     cmd;
    logic [INDEX_WIDTH-1:0]         cmd_index;
    logic [TAG_WIDTH-1:0]           cmd_tag;
    logic [LINE_WIDTH-1:0]          cmd_line;
    logic                           cmd_ready;
    logic                           done;
    logic [LINE_WIDTH-1:0]          done_line;

    // array port
    logic [INDEX_WIDTH-1:0]         arr_index;
    logic                           arr_rd_valid;
    logic                           arr_rd_dirty;
    logic [TAG_WIDTH-1:0]           arr_rd_tag;
    logic [LINE_WIDTH-1:0]          arr_rd_line;
    logic                           arr_we;
    logic                           arr_wr_valid;
    logic                           arr_wr_dirty;
    logic [TAG_WIDTH-1:0]           arr_wr_tag;
    logic [LINE_WIDTH-1:0]          arr_wr_line;

    // memory bus
    logic [TAG_WIDTH+INDEX_WIDTH-1:0] mem_addr;
    logic                           mem_read_req;
    logic                           mem_write_req;
    logic [LINE_WIDTH-1:0]          mem_write_line;
    logic [LINE_WIDTH-1:0]          mem_read_line;
    logic                           mem_read_done;
    logic                           mem_write_done;

    modport slave (
        input  cmd_valid, cmd, cmd_index, cmd_tag, cmd_line,
        input  arr_rd_valid, arr_rd_dirty, arr_rd_tag, arr_rd_line,
        input  mem_read_line, mem_read_done, mem_write_done,
        output cmd_ready, done, done_line,
        output arr_index, arr_we, arr_wr_valid, arr_wr_dirty, arr_wr_tag, arr_wr_line,
        output mem_addr, mem_read_req, mem_write_req, mem_write_line
    );

    modport master (
        output cmd_valid, cmd, cmd_index, cmd_tag, cmd_line,
        output arr_rd_valid, arr_rd_dirty, arr_rd_tag, arr_rd_line,
        output mem_read_line, mem_read_done, mem_write_done,
        input  cmd_ready, done, done_line,
        input  arr_index, arr_we, arr_wr_valid, arr_wr_dirty, arr_wr_tag, arr_wr_line,
        input  mem_addr, mem_read_req, mem_write_req, mem_write_line
    );
endinterface

// File: rtl/dcache_replace_logic.sv
// ---------------------------------------------------------------------------
// dcache_replace_logic
// Line-fill / write-back engine behind the direct-mapped D$. It runs one
// command at a time. The commands are None, WriteThrough, Replace and
// Invalidate. The engine owns the array write port, and after reset it
// sweeps every entry to invalid.
// Ports:
//   clk   : clock, all state on the rising edge
//   rst_n : asynchronous active-low reset
//   bus   : dcache_replace_logic_if.slave
//           - command channel: cmd_valid/cmd/cmd_index/cmd_tag/cmd_line in;
//             cmd_ready/done/done_line out
//           - array port: arr_index/arr_we/arr_wr_* out; arr_rd_* in.
//             The array read at arr_index is combinational.
//           - memory bus: mem_addr/mem_read_req/mem_write_req/mem_write_line
//             out; mem_read_line/mem_read_done/mem_write_done in
// Every output is a register. It is loaded on the same edge that enters
// the state the output belongs to.
// ---------------------------------------------------------------------------
module dcache_replace_logic #(
    parameter int LINE_WIDTH  = 128,
    parameter int INDEX_WIDTH = 4,
    parameter int TAG_WIDTH   = 26,
    parameter int RESET_CYCLE = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    dcache_replace_logic_if.slave  bus
);
    localparam logic [1:0] CMD_NONE    = 2'd0;
    localparam logic [1:0] CMD_WT      = 2'd1;
    localparam logic [1:0] CMD_REPLACE = 2'd2;
    localparam int         CNT_W       = $clog2(RESET_CYCLE + 1);

    typedef enum logic [2:0] {
        S_SWEEP,
        S_IDLE,
        S_ARRAY_READ,
        S_WRITEBACK,
        S_WT_WRITE,
        S_REFILL,
        S_ARRAY_WRITE,
        S_DONE
    } state_t;

    state_t                         state_reg;
    logic [CNT_W-1:0]               sweep_cnt_reg;
    logic [1:0]                     op_reg;
    logic [TAG_WIDTH-1:0]           tag_reg;

    logic                           cmd_ready_reg;
    logic                           done_reg;
    logic [LINE_WIDTH-1:0]          done_line_reg;
    logic [INDEX_WIDTH-1:0]         arr_index_reg;
    logic                           arr_we_reg;
    logic                           arr_wr_valid_reg;
    logic                           arr_wr_dirty_reg;
    logic [TAG_WIDTH-1:0]           arr_wr_tag_reg;
    logic [LINE_WIDTH-1:0]          arr_wr_line_reg;
    logic [TAG_WIDTH+INDEX_WIDTH-1:0] mem_addr_reg;
    logic                           mem_read_req_reg;
    logic                           mem_write_req_reg;
    logic [LINE_WIDTH-1:0]          mem_write_line_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg          <= S_SWEEP;
            sweep_cnt_reg      <= '0;
            op_reg             <= CMD_NONE;
            tag_reg            <= '0;
            cmd_ready_reg      <= 1'b0;
            done_reg           <= 1'b0;
            done_line_reg      <= '0;
            arr_index_reg      <= '0;
            arr_we_reg         <= 1'b0;
            arr_wr_valid_reg   <= 1'b0;
            arr_wr_dirty_reg   <= 1'b0;
            arr_wr_tag_reg     <= '0;
            arr_wr_line_reg    <= '0;
            mem_addr_reg       <= '0;
            mem_read_req_reg   <= 1'b0;
            mem_write_req_reg  <= 1'b0;
            mem_write_line_reg <= '0;
        end else begin
            // Pulse outputs and the array write payload default to zero.
            // An invalidating write (sweep or Invalidate) therefore only
            // needs to raise arr_we.
            done_reg         <= 1'b0;
            done_line_reg    <= '0;
            arr_we_reg       <= 1'b0;
            arr_wr_valid_reg <= 1'b0;
            arr_wr_dirty_reg <= 1'b0;
            arr_wr_tag_reg   <= '0;
            arr_wr_line_reg  <= '0;

            case (state_reg)
                S_SWEEP: begin
                    if (sweep_cnt_reg == CNT_W'(RESET_CYCLE)) begin
                        state_reg     <= S_IDLE;
                        cmd_ready_reg <= 1'b1;
                    end else begin
                        arr_we_reg    <= 1'b1;
                        arr_index_reg <= sweep_cnt_reg[INDEX_WIDTH-1:0];
                        sweep_cnt_reg <= sweep_cnt_reg + 1'b1;
                    end
                end

                S_IDLE: begin
                    if (bus.cmd_valid && bus.cmd != CMD_NONE) begin
                        cmd_ready_reg <= 1'b0;
                        op_reg        <= bus.cmd;
                        tag_reg       <= bus.cmd_tag;
                        arr_index_reg <= bus.cmd_index;
                        if (bus.cmd == CMD_WT) begin
                            state_reg          <= S_WT_WRITE;
                            mem_write_req_reg  <= 1'b1;
                            mem_addr_reg       <= {bus.cmd_tag, bus.cmd_index};
                            mem_write_line_reg <= bus.cmd_line;
                        end else begin
                            state_reg <= S_ARRAY_READ;
                        end
                    end
                end

                S_ARRAY_READ: begin
                    // The victim's tag and line go straight into the
                    // write-back request registers. They stay there
                    // unchanged until the write completes.
                    if (bus.arr_rd_valid && bus.arr_rd_dirty) begin
                        state_reg          <= S_WRITEBACK;
                        mem_write_req_reg  <= 1'b1;
                        mem_addr_reg       <= {bus.arr_rd_tag, arr_index_reg};
                        mem_write_line_reg <= bus.arr_rd_line;
                    end else if (op_reg == CMD_REPLACE) begin
                        state_reg        <= S_REFILL;
                        mem_read_req_reg <= 1'b1;
                        mem_addr_reg     <= {tag_reg, arr_index_reg};
                    end else begin
                        state_reg  <= S_ARRAY_WRITE;
                        arr_we_reg <= 1'b1;
                        done_reg   <= 1'b1;
                    end
                end

                S_WRITEBACK: begin
                    if (bus.mem_write_done) begin
                        mem_write_req_reg <= 1'b0;
                        if (op_reg == CMD_REPLACE) begin
                            state_reg        <= S_REFILL;
                            mem_read_req_reg <= 1'b1;
                            mem_addr_reg     <= {tag_reg, arr_index_reg};
                        end else begin
                            state_reg  <= S_ARRAY_WRITE;
                            arr_we_reg <= 1'b1;
                            done_reg   <= 1'b1;
                        end
                    end
                end

                S_WT_WRITE: begin
                    if (bus.mem_write_done) begin
                        mem_write_req_reg <= 1'b0;
                        state_reg         <= S_DONE;
                        done_reg          <= 1'b1;
                    end
                end

                S_REFILL: begin
                    // The refill data is latched in two places on the same
                    // edge: the array write data and done_line.
                    if (bus.mem_read_done) begin
                        mem_read_req_reg <= 1'b0;
                        state_reg        <= S_ARRAY_WRITE;
                        arr_we_reg       <= 1'b1;
                        arr_wr_valid_reg <= 1'b1;
                        arr_wr_tag_reg   <= tag_reg;
                        arr_wr_line_reg  <= bus.mem_read_line;
                        done_reg         <= 1'b1;
                        done_line_reg    <= bus.mem_read_line;
                    end
                end

                S_ARRAY_WRITE, S_DONE: begin
                    state_reg     <= S_IDLE;
                    cmd_ready_reg <= 1'b1;
                end

                default: begin
                    state_reg     <= S_IDLE;
                    cmd_ready_reg <= 1'b1;
                end
            endcase
        end
    end

    assign bus.cmd_ready      = cmd_ready_reg;
    assign bus.done           = done_reg;
    assign bus.done_line      = done_line_reg;
    assign bus.arr_index      = arr_index_reg;
    assign bus.arr_we         = arr_we_reg;
    assign bus.arr_wr_valid   = arr_wr_valid_reg;
    assign bus.arr_wr_dirty   = arr_wr_dirty_reg;
    assign bus.arr_wr_tag     = arr_wr_tag_reg;
    assign bus.arr_wr_line    = arr_wr_line_reg;
    assign bus.mem_addr       = mem_addr_reg;
    assign bus.mem_read_req   = mem_read_req_reg;
    assign bus.mem_write_req  = mem_write_req_reg;
    assign bus.mem_write_line = mem_write_line_reg;
endmodule

// File: tb/tb_dcache_replace_logic.sv
// ---------------------------------------------------------------------------
// tb_dcache_replace_logic
// Bench for dcache_replace_logic.
// The stimulus pushes every expected observable event into a queue. There
// are four kinds: array write, memory write request, memory read request
// and done. A monitor pops one entry each time the DUT shows such an event
// and compares it.
// A small array model feeds the combinational array read port.
// A memory responder answers each request mem_lat cycles after it rises.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_dcache_replace_logic;
    localparam int LW = 128;
    localparam int IW = 4;
    localparam int TW = 26;
    localparam int AW = TW + IW;
    localparam logic [1:0] C_NONE = 2'd0;
    localparam logic [1:0] C_WT   = 2'd1;
    localparam logic [1:0] C_REP  = 2'd2;
    localparam logic [1:0] C_INV  = 2'd3;
    localparam int K_ARR  = 0;
    localparam int K_MWR  = 1;
    localparam int K_MRD  = 2;
    localparam int K_DONE = 3;

    typedef struct {
        int           kind;
        logic [AW-1:0] addr;   // {tag,index} for array writes and memory requests
        logic [1:0]   vd;      // {valid,dirty} for array writes
        logic [LW-1:0] line;
        int           lat;     // done latency from accept, -1 = not checked
    } ev_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dcache_replace_logic_if #(.LINE_WIDTH(LW), .INDEX_WIDTH(IW), .TAG_WIDTH(TW)) bus();

    dcache_replace_logic #(
        .LINE_WIDTH(LW), .INDEX_WIDTH(IW), .TAG_WIDTH(TW), .RESET_CYCLE(16)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int  total = 0;
    int  bad = 0;
    int  cyc = 0;
    int  accept_cyc = 0;
    int  mem_lat = 4;
    bit  resp_mute = 1'b0;
    bit  inject_rd = 1'b0;
    bit  inject_wr = 1'b0;
    ev_t exp_q[$];

    // preset request, consumed by the array model at the next negedge
    bit            pre_en = 1'b0;
    logic [IW-1:0] pre_idx;
    logic          pre_v, pre_d;
    logic [TW-1:0] pre_tag;
    logic [LW-1:0] pre_line;

    logic          m_valid [16];
    logic          m_dirty [16];
    logic [TW-1:0] m_tag   [16];
    logic [LW-1:0] m_line  [16];

    assign bus.arr_rd_valid = m_valid[bus.arr_index];
    assign bus.arr_rd_dirty = m_dirty[bus.arr_index];
    assign bus.arr_rd_tag   = m_tag[bus.arr_index];
    assign bus.arr_rd_line  = m_line[bus.arr_index];

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [LW-1:0] pat(input logic [AW-1:0] a);
        return {4{2'b10, a}};
    endfunction

    function automatic void push(input int k, input logic [AW-1:0] a, input logic [1:0] vd,
                                 input logic [LW-1:0] l, input int lat);
        ev_t e;
        e.kind = k; e.addr = a; e.vd = vd; e.line = l; e.lat = lat;
        exp_q.push_back(e);
    endfunction

    task automatic chk(input string nm, input logic [199:0] act, input logic [199:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    task automatic take(input int k, input string nm, input logic [199:0] act);
        ev_t e;
        if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL %s unexpected: actual=%0h required=none", nm, act);
            return;
        end
        e = exp_q.pop_front();
        chk({nm, "_kind"}, k, e.kind);
        case (k)
            K_ARR:  chk(nm, act, {40'b0, e.addr, e.vd, e.line});
            K_MWR:  chk(nm, act, {42'b0, e.addr, e.line});
            K_MRD:  chk(nm, act, {170'b0, e.addr});
            default: begin
                chk(nm, act, {72'b0, e.line});
                if (e.lat >= 0) chk("done_latency", cyc - accept_cyc, e.lat);
            end
        endcase
        $display("event %s at cycle %0d checked", nm, cyc - accept_cyc);
    endtask

    // array model: sole owner of m_*
    initial begin
        for (int i = 0; i < 16; i++) begin
            m_valid[i] = 1'b1; m_dirty[i] = 1'b1; m_tag[i] = '1; m_line[i] = '1;
        end
        forever begin
            @(negedge clk);
            if (pre_en) begin
                m_valid[pre_idx] = pre_v; m_dirty[pre_idx] = pre_d;
                m_tag[pre_idx] = pre_tag; m_line[pre_idx] = pre_line;
            end
            if (rst_n && bus.arr_we) begin
                m_valid[bus.arr_index] = bus.arr_wr_valid;
                m_dirty[bus.arr_index] = bus.arr_wr_dirty;
                m_tag[bus.arr_index]   = bus.arr_wr_tag;
                m_line[bus.arr_index]  = bus.arr_wr_line;
            end
        end
    end

    // memory responder
    initial begin
        bit busy = 1'b0;
        bit is_rd = 1'b0;
        bit prev_rd = 1'b0;
        bit prev_wr = 1'b0;
        int cnt = 0;
        bus.mem_read_done = 1'b0;
        bus.mem_write_done = 1'b0;
        bus.mem_read_line = '0;
        forever begin
            @(negedge clk);
            bus.mem_read_done = inject_rd;
            bus.mem_write_done = inject_wr;
            if (inject_rd) bus.mem_read_line = '1;
            if (!rst_n) begin
                busy = 1'b0;
            end else if (!resp_mute) begin
                if ((bus.mem_read_req && !prev_rd) || (bus.mem_write_req && !prev_wr)) begin
                    busy = 1'b1; cnt = mem_lat; is_rd = bus.mem_read_req;
                end
                if (busy) begin
                    if (cnt == 0) begin
                        busy = 1'b0;
                        if (is_rd) begin
                            bus.mem_read_done = 1'b1;
                            bus.mem_read_line = pat(bus.mem_addr);
                        end else begin
                            bus.mem_write_done = 1'b1;
                        end
                    end else begin
                        cnt--;
                    end
                end
            end
            prev_rd = rst_n && bus.mem_read_req;
            prev_wr = rst_n && bus.mem_write_req;
        end
    end

    // monitor
    initial begin
        bit prev_rd = 1'b0;
        bit prev_wr = 1'b0;
        logic [AW-1:0] prev_addr = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_rd = 1'b0; prev_wr = 1'b0;
                continue;
            end
            if (bus.arr_we)
                take(K_ARR, "arr_write", {40'b0, bus.arr_wr_tag, bus.arr_index,
                                          bus.arr_wr_valid, bus.arr_wr_dirty, bus.arr_wr_line});
            if (bus.mem_write_req && !prev_wr)
                take(K_MWR, "mem_write_req", {42'b0, bus.mem_addr, bus.mem_write_line});
            if (bus.mem_read_req && !prev_rd)
                take(K_MRD, "mem_read_req", {170'b0, bus.mem_addr});
            if (bus.done)
                take(K_DONE, "done", {72'b0, bus.done_line});
            if (bus.mem_read_req || bus.mem_write_req)
                chk("one_request", bus.mem_read_req & bus.mem_write_req, 1'b0);
            if ((bus.mem_read_req && prev_rd) || (bus.mem_write_req && prev_wr))
                chk("addr_stable", bus.mem_addr, prev_addr);
            prev_rd = bus.mem_read_req;
            prev_wr = bus.mem_write_req;
            prev_addr = bus.mem_addr;
        end
    end

    task automatic preset(input logic [IW-1:0] idx, input logic v, input logic d,
                          input logic [TW-1:0] tag, input logic [LW-1:0] line);
        @(posedge clk); #1;
        pre_idx = idx; pre_v = v; pre_d = d; pre_tag = tag; pre_line = line; pre_en = 1'b1;
        @(posedge clk); #1;
        pre_en = 1'b0;
    endtask

    task automatic issue(input logic [1:0] c, input logic [IW-1:0] idx,
                         input logic [TW-1:0] tag, input logic [LW-1:0] line);
        int n = 0;
        @(negedge clk);
        while (!bus.cmd_ready && n < 200) begin @(negedge clk); n++; end
        chk("ready_before_issue", bus.cmd_ready, 1'b1);
        bus.cmd_valid = 1'b1; bus.cmd = c; bus.cmd_index = idx;
        bus.cmd_tag = tag; bus.cmd_line = line;
        accept_cyc = cyc;
        @(negedge clk);
        bus.cmd_valid = 1'b0; bus.cmd = C_NONE;
        chk("ready_drop", bus.cmd_ready, 1'b0);
    endtask

    task automatic drain(input string nm);
        int n = 0;
        while ((exp_q.size() != 0 || !bus.cmd_ready) && n < 300) begin
            @(negedge clk); n++;
        end
        if (n >= 300) begin
            total++; bad++;
            $display("FAIL %s timeout: pending=%0d required=0", nm, exp_q.size());
        end
    endtask

    // Expects 16 invalidating writes, then releases reset and times cmd_ready.
    task automatic sweep(input string nm);
        int n;
        for (int i = 0; i < 16; i++) push(K_ARR, AW'(i), 2'b00, '0, -1);
        @(negedge clk);
        rst_n = 1'b1;
        for (n = 1; n <= 40; n++) begin
            @(posedge clk); #1;
            if (bus.cmd_ready) break;
        end
        chk({nm, "_ready_cycle"}, n, 17);
        chk({nm, "_write_count"}, exp_q.size(), 0);
    endtask

    initial begin
        int n;
        logic [LW-1:0] l5, l7, lwt;
        l5  = {4{32'h5A5A_0005}};
        l7  = {4{32'h7777_0007}};
        lwt = {4{32'hDEAD_BEEF}};
        bus.cmd_valid = 1'b0; bus.cmd = C_NONE; bus.cmd_index = '0;
        bus.cmd_tag = '0; bus.cmd_line = '0;

        // reset values
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_flags", {bus.cmd_ready, bus.done, bus.arr_we, bus.mem_read_req, bus.mem_write_req}, 5'b0);
        chk("rst_mem_addr", bus.mem_addr, 0);
        chk("rst_done_line", bus.done_line, 0);
        sweep("sweep1");

        // clean Replace, memory answers 4 cycles after the request
        mem_lat = 4;
        push(K_MRD, 30'h0123453, 2'b00, '0, -1);
        push(K_ARR, 30'h0123453, 2'b10, pat(30'h0123453), -1);
        push(K_DONE, '0, 2'b00, pat(30'h0123453), 7);
        issue(C_REP, 4'h3, 26'h12345, '0);
        drain("clean_replace");

        // dirty Replace: write back 0xAAA5, then refill 0xBBB5
        mem_lat = 2;
        preset(4'h5, 1'b1, 1'b1, 26'hAAA, l5);
        push(K_MWR, 30'h000AAA5, 2'b00, l5, -1);
        push(K_MRD, 30'h000BBB5, 2'b00, '0, -1);
        push(K_ARR, 30'h000BBB5, 2'b10, pat(30'h000BBB5), -1);
        push(K_DONE, '0, 2'b00, pat(30'h000BBB5), 8);
        issue(C_REP, 4'h5, 26'hBBB, '0);
        drain("dirty_replace");

        // dirty Invalidate: write back, then clear the entry
        mem_lat = 3;
        preset(4'h7, 1'b1, 1'b1, 26'h777, l7);
        push(K_MWR, 30'h0007777, 2'b00, l7, -1);
        push(K_ARR, 30'h0000007, 2'b00, '0, -1);
        push(K_DONE, '0, 2'b00, '0, 6);
        issue(C_INV, 4'h7, 26'h0, '0);
        drain("dirty_invalidate");

        // clean Invalidate: no memory traffic, done at cycle 2
        preset(4'h8, 1'b1, 1'b0, 26'h88, {4{32'h8888_8888}});
        push(K_ARR, 30'h0000008, 2'b00, '0, -1);
        push(K_DONE, '0, 2'b00, '0, 2);
        issue(C_INV, 4'h8, 26'h0, '0);
        drain("clean_invalidate");

        // WriteThrough: memory write only, no array write
        mem_lat = 3;
        push(K_MWR, 30'h000001F, 2'b00, lwt, -1);
        push(K_DONE, '0, 2'b00, '0, 5);
        issue(C_WT, 4'hF, 26'h1, lwt);
        drain("write_through");

        // cmd=None is ignored
        @(negedge clk);
        bus.cmd_valid = 1'b1; bus.cmd = C_NONE;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("none_ready", bus.cmd_ready, 1'b1);
        end
        bus.cmd_valid = 1'b0;

        // zero-latency memory, all-ones tag at index 0
        mem_lat = 0;
        push(K_MRD, 30'h3FFFFFF0, 2'b00, '0, -1);
        push(K_ARR, 30'h3FFFFFF0, 2'b10, pat(30'h3FFFFFF0), -1);
        push(K_DONE, '0, 2'b00, pat(30'h3FFFFFF0), 3);
        issue(C_REP, 4'h0, 26'h3FFFFFF, '0);
        drain("replace_zero_latency");

        // valid but clean victim: Replace goes straight to refill
        mem_lat = 1;
        push(K_MRD, 30'h0000023, 2'b00, '0, -1);
        push(K_ARR, 30'h0000023, 2'b10, pat(30'h0000023), -1);
        push(K_DONE, '0, 2'b00, pat(30'h0000023), 4);
        issue(C_REP, 4'h3, 26'h2, '0);
        drain("replace_clean_victim");

        // reset in the middle of REFILL
        resp_mute = 1'b1;
        push(K_MRD, 30'h0000559, 2'b00, '0, -1);
        issue(C_REP, 4'h9, 26'h55, '0);
        n = 0;
        while (!bus.mem_read_req && n < 20) begin @(negedge clk); n++; end
        chk("refill_req_seen", bus.mem_read_req, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_read_req", bus.mem_read_req, 1'b0);
        chk("abort_ready", bus.cmd_ready, 1'b0);
        @(posedge clk); #1 inject_rd = 1'b1;
        @(posedge clk); #1 inject_rd = 1'b0;
        resp_mute = 1'b0;
        sweep("sweep2");

        // stray done pulses while idle change nothing
        @(posedge clk); #1 inject_rd = 1'b1; inject_wr = 1'b1;
        @(posedge clk); #1 inject_rd = 1'b0; inject_wr = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("stray_done_ready", bus.cmd_ready, 1'b1);
        end
        chk("stray_done_quiet", {bus.mem_read_req, bus.mem_write_req, bus.arr_we, bus.done}, 4'b0);

        chk("queue_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end
endmodule
